// File: rtl/led_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_sweep_ctrl_if : control/status bundle for the one-hot LED sweeper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface led_sweep_ctrl_if #(
  parameter int N     = 4,
  parameter int DIV_W = 8
);

  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [3:0]       dwell;
  logic [N-1:0]     leds;
  logic             busy;
  logic             sweep_done;

  modport master (
    output start,
    output stop,
    output mode,
    output div,
    output dwell,
    input  leds,
    input  busy,
    input  sweep_done
  );

  modport slave (
    input  start,
    input  stop,
    input  mode,
    input  div,
    input  dwell,
    output leds,
    output busy,
    output sweep_done
  );

endinterface

`default_nettype wire

// File: rtl/led_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// led_sweep_ctrl : one-hot LED sweeper with bounce, rotate and single modes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_sweep_ctrl #(
  parameter int N     = 4,
  parameter int DIV_W = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  led_sweep_ctrl_if.slave bus
);

  localparam logic [N-1:0] c_LED_HOME = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_UP        = 3'd1,
    S_DOWN      = 3'd2,
    S_DWELL_TOP = 3'd3,
    S_DWELL_BOT = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [N-1:0]     leds_q;
  logic [N-1:0]     leds_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [3:0]       dwell_cnt_q;
  logic [3:0]       dwell_cnt_d;

  // Configuration captured at start; held until the block returns to idle.
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       dwell_q;

  logic             w_tick;
  logic             w_rotate;
  logic             w_single;
  logic             w_latch;
  logic             w_dwell_last;
  logic [N-1:0]     w_rotl;

  assign w_tick       = (cnt_q == div_q);
  assign w_rotate     = (mode_q == 2'd1);
  assign w_single     = (mode_q == 2'd2);
  assign w_dwell_last = (dwell_cnt_q == (dwell_q - 4'd1));
  assign w_rotl       = {leds_q[N-2:0], leds_q[N-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      leds_q      <= c_LED_HOME;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      dwell_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      leds_q      <= leds_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 2'd0;
      div_q   <= '0;
      dwell_q <= 4'd0;
    end else if (w_latch) begin
      mode_q  <= bus.mode;
      div_q   <= bus.div;
      dwell_q <= bus.dwell;
    end
  end

  always_comb begin
    state_d     = state_q;
    leds_d      = leds_q;
    cnt_d       = cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    done_d      = 1'b0;
    w_latch     = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = w_tick ? '0 : (cnt_q + DIV_W'(1));
    end

    case (state_q)
      S_IDLE: begin
        cnt_d       = '0;
        dwell_cnt_d = 4'd0;
        leds_d      = c_LED_HOME;
        if (bus.start) begin
          w_latch = 1'b1;
          state_d = S_UP;
        end
      end

      S_UP: begin
        if (w_tick) begin
          if (w_rotate) begin
            leds_d = w_rotl;
            done_d = leds_q[N-1];
          end else begin
            leds_d = leds_q << 1;
            if (leds_q[N-2]) begin
              state_d = (dwell_q != 4'd0) ? S_DWELL_TOP : S_DOWN;
            end
          end
        end
      end

      S_DOWN: begin
        if (w_tick) begin
          leds_d = leds_q >> 1;
          if (leds_q[1]) begin
            done_d = 1'b1;
            if (w_single) begin
              state_d = S_IDLE;
            end else begin
              state_d = (dwell_q != 4'd0) ? S_DWELL_BOT : S_UP;
            end
          end
        end
      end

      S_DWELL_TOP,
      S_DWELL_BOT: begin
        // The last dwell tick only changes direction; the LEDs move on the next tick.
        if (w_tick) begin
          if (w_dwell_last) begin
            dwell_cnt_d = 4'd0;
            state_d     = (state_q == S_DWELL_TOP) ? S_DOWN : S_UP;
          end else begin
            dwell_cnt_d = dwell_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        leds_d  = c_LED_HOME;
      end
    endcase

    // Abort overrides everything, including a start seen in the same cycle.
    if (bus.stop) begin
      state_d     = S_IDLE;
      leds_d      = c_LED_HOME;
      cnt_d       = '0;
      dwell_cnt_d = 4'd0;
      done_d      = 1'b0;
      w_latch     = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.leds       = leds_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = done_q;

  a_leds_onehot : assert property (@(posedge clk) disable iff (rst) $onehot(leds_q));
  a_busy_state  : assert property (@(posedge clk) disable iff (rst) busy_q == (state_q != S_IDLE));
  a_done_home   : assert property (@(posedge clk) disable iff (rst) done_q |-> (leds_q == c_LED_HOME));

endmodule

`default_nettype wire
